// File: rtl/trellis_pkg.sv
// Shared helpers for the trellis carrier-loop blocks: width math, saturation
// and the unity-rotation exponent.
package trellis_pkg;

   // Unity rotation is 2^-(UNITY_SHIFT-1) in Q1.(OUT_W-1), leaving headroom above 1.0.
   localparam int UNITY_SHIFT = 4;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (x > hi)
         return hi;
      else if (x < lo)
         return lo;
      else
         return x;
   endfunction

endpackage

// File: rtl/trellis_leak_update.sv
// One rail of the leaky integrator: acc - (acc >>> K) + (e >>> K), saturated to ACC_W.
module trellis_leak_update
   import trellis_pkg::*;
#(
   parameter int ACC_W = 35
) (
   input  logic signed [ACC_W-1:0] i_acc,
   input  logic signed [ACC_W-1:0] i_err,
   input  logic        [3:0]       i_shift,
   output logic signed [ACC_W-1:0] o_acc,
   output logic                    o_sat
);

   logic signed [ACC_W+1:0] w_acc_x;
   logic signed [ACC_W+1:0] w_err_x;
   logic signed [ACC_W+1:0] w_sum;
   logic signed [63:0]      w_sum_64;
   logic signed [63:0]      w_sat;

   // Two guard bits keep the intermediate sum exact before clamping.
   assign w_acc_x  = {{2{i_acc[ACC_W-1]}}, i_acc};
   assign w_err_x  = {{2{i_err[ACC_W-1]}}, i_err};
   assign w_sum    = w_acc_x - (w_acc_x >>> i_shift) + (w_err_x >>> i_shift);
   assign w_sum_64 = {{(64-ACC_W-2){w_sum[ACC_W+1]}}, w_sum};
   assign w_sat    = sat(w_sum_64, ACC_W);
   assign o_acc    = w_sat[ACC_W-1:0];
   assign o_sat    = (w_sat != w_sum_64);

endmodule

// File: rtl/trellis_leaky_rotator.sv
// Per-channel leaky integrator of complex phase error producing a conjugated
// rotation vector; two-stage pipeline with read-modify-write forwarding.
module trellis_leaky_rotator
   import trellis_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int ERR_W  = 10,
   parameter  int OUT_W  = 18,
   parameter  int FRAC_W = 17,
   localparam int CH_W   = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH),
   localparam int ACC_W  = OUT_W + FRAC_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    errValid,
   input  logic        [CH_W-1:0]  errCh,
   input  logic signed [ERR_W-1:0] errReal,
   input  logic signed [ERR_W-1:0] errImag,
   input  logic        [3:0]       leakShift,
   input  logic                    enableLoop,
   input  logic                    freeze,
   input  logic                    clearValid,
   input  logic        [CH_W-1:0]  clearCh,
   output logic                    rotValid,
   output logic        [CH_W-1:0]  rotCh,
   output logic signed [OUT_W-1:0] rotReal,
   output logic signed [OUT_W-1:0] rotImag,
   output logic                    satFlag
);

   localparam logic [CH_W:0]      NUM_CH_L = (CH_W+1)'(NUM_CH);
   localparam logic [OUT_W-1:0]   UNITY    = {{(UNITY_SHIFT-1){1'b0}}, 1'b1, {(OUT_W-UNITY_SHIFT){1'b0}}};
   localparam logic [OUT_W-1:0]   OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0]   OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};

   logic signed [ACC_W-1:0] r_acc_re [NUM_CH];
   logic signed [ACC_W-1:0] r_acc_im [NUM_CH];

   logic                    r_s1_valid;
   logic        [CH_W-1:0]  r_s1_ch;
   logic signed [ERR_W-1:0] r_s1_err_re;
   logic signed [ERR_W-1:0] r_s1_err_im;
   logic signed [ACC_W-1:0] r_s1_acc_re;
   logic signed [ACC_W-1:0] r_s1_acc_im;

   logic                    w_ch_ok;
   logic                    w_clr_en;
   logic signed [ACC_W-1:0] w_rd_re;
   logic signed [ACC_W-1:0] w_rd_im;
   logic signed [ACC_W-1:0] w_err_re;
   logic signed [ACC_W-1:0] w_err_im;
   logic signed [ACC_W-1:0] w_upd_re;
   logic signed [ACC_W-1:0] w_upd_im;
   logic                    w_sat_re;
   logic                    w_sat_im;
   logic signed [ACC_W-1:0] w_wr_re;
   logic signed [ACC_W-1:0] w_wr_im;
   logic signed [OUT_W-1:0] w_top_im;
   logic signed [OUT_W-1:0] w_neg_im;

   assign w_ch_ok  = ({1'b0, errCh} < NUM_CH_L);
   assign w_clr_en = clearValid && ({1'b0, clearCh} < NUM_CH_L);

   // Stage-1 read: a same-cycle clear beats the in-flight stage-2 write, which beats the array.
   always_comb begin
      w_rd_re = r_acc_re[errCh];
      w_rd_im = r_acc_im[errCh];
      if (w_clr_en && clearCh == errCh) begin
         w_rd_re = '0;
         w_rd_im = '0;
      end else if (r_s1_valid && r_s1_ch == errCh) begin
         w_rd_re = w_wr_re;
         w_rd_im = w_wr_im;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_ch     <= '0;
         r_s1_err_re <= '0;
         r_s1_err_im <= '0;
         r_s1_acc_re <= '0;
         r_s1_acc_im <= '0;
      end else begin
         r_s1_valid <= errValid && w_ch_ok;
         if (errValid && w_ch_ok) begin
            r_s1_ch     <= errCh;
            r_s1_err_re <= errReal;
            r_s1_err_im <= errImag;
            r_s1_acc_re <= w_rd_re;
            r_s1_acc_im <= w_rd_im;
         end
      end
   end

   assign w_err_re = {r_s1_err_re, {(ACC_W-ERR_W){1'b0}}};
   assign w_err_im = {r_s1_err_im, {(ACC_W-ERR_W){1'b0}}};

   trellis_leak_update #(.ACC_W(ACC_W)) u_leak_re (
      .i_acc   (r_s1_acc_re),
      .i_err   (w_err_re),
      .i_shift (leakShift),
      .o_acc   (w_upd_re),
      .o_sat   (w_sat_re)
   );

   trellis_leak_update #(.ACC_W(ACC_W)) u_leak_im (
      .i_acc   (r_s1_acc_im),
      .i_err   (w_err_im),
      .i_shift (leakShift),
      .o_acc   (w_upd_im),
      .o_sat   (w_sat_im)
   );

   assign w_wr_re  = freeze ? r_s1_acc_re : w_upd_re;
   assign w_wr_im  = freeze ? r_s1_acc_im : w_upd_im;
   assign w_top_im = w_wr_im[ACC_W-1 -: OUT_W];
   assign w_neg_im = (w_top_im == OUT_MIN) ? OUT_MAX : -w_top_im;

   // Clear is assigned last so it overrides a colliding stage-2 write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_acc_re[i] <= '0;
            r_acc_im[i] <= '0;
         end
      end else begin
         if (r_s1_valid) begin
            r_acc_re[r_s1_ch] <= w_wr_re;
            r_acc_im[r_s1_ch] <= w_wr_im;
         end
         if (w_clr_en) begin
            r_acc_re[clearCh] <= '0;
            r_acc_im[clearCh] <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rotValid <= 1'b0;
         rotCh    <= '0;
         rotReal  <= UNITY;
         rotImag  <= '0;
         satFlag  <= 1'b0;
      end else begin
         rotValid <= r_s1_valid;
         if (r_s1_valid) begin
            rotCh <= r_s1_ch;
            if (enableLoop) begin
               rotReal <= w_wr_re[ACC_W-1 -: OUT_W];
               rotImag <= w_neg_im;
            end else begin
               rotReal <= UNITY;
               rotImag <= '0;
            end
            if (!freeze && (w_sat_re || w_sat_im))
               satFlag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_trellis_leaky_rotator.sv
// Directed bench for trellis_leaky_rotator with hand-computed rotation values.
module tb_trellis_leaky_rotator;

   logic               clk;
   logic               reset;
   logic               errValid;
   logic        [1:0]  errCh;
   logic signed [9:0]  errReal;
   logic signed [9:0]  errImag;
   logic        [3:0]  leakShift;
   logic               enableLoop;
   logic               freeze;
   logic               clearValid;
   logic        [1:0]  clearCh;
   logic               rotValid;
   logic        [1:0]  rotCh;
   logic signed [17:0] rotReal;
   logic signed [17:0] rotImag;
   logic               satFlag;

   typedef struct packed {
      logic [1:0]  ch;
      logic [17:0] re;
      logic [17:0] im;
   } out_t;

   out_t q[$];
   int   total = 0;
   int   bad   = 0;

   trellis_leaky_rotator dut (
      .clk        (clk),
      .reset      (reset),
      .errValid   (errValid),
      .errCh      (errCh),
      .errReal    (errReal),
      .errImag    (errImag),
      .leakShift  (leakShift),
      .enableLoop (enableLoop),
      .freeze     (freeze),
      .clearValid (clearValid),
      .clearCh    (clearCh),
      .rotValid   (rotValid),
      .rotCh      (rotCh),
      .rotReal    (rotReal),
      .rotImag    (rotImag),
      .satFlag    (satFlag)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset && rotValid) begin
         q.push_back({rotCh, rotReal, rotImag});
         $display("out ch=%0d re=%h im=%h sat=%0b", rotCh, rotReal, rotImag, satFlag);
      end
   end

   task automatic drive(input logic [1:0] ch, input logic [9:0] re, input logic [9:0] im);
      errValid = 1'b1;
      errCh    = ch;
      errReal  = re;
      errImag  = im;
      @(posedge clk);
      #1;
      errValid = 1'b0;
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic take(output out_t o, output bit ok);
      ok = (q.size() > 0);
      if (ok) o = q.pop_front();
      else    o = '0;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (rotValid !== 1'b0 || rotCh !== 2'd0 || rotReal !== 18'h04000 || rotImag !== 18'h0 || satFlag !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got v=%b ch=%0d re=%h im=%h sat=%b want v=0 ch=0 re=04000 im=0 sat=0",
                  rotValid, rotCh, rotReal, rotImag, satFlag);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      settle();
      total++;
      if (rotValid !== 1'b0 || q.size() != 0) begin
         bad++;
         $display("FAIL reset_idle got v=%b outputs=%0d want v=0 outputs=0", rotValid, q.size());
      end
   endtask

   task automatic test_latency_k0();
      leakShift = 4'd0;
      drive(2'd0, 10'h100, 10'h000);
      @(negedge clk);
      total++;
      if (rotValid !== 1'b0) begin
         bad++;
         $display("FAIL latency_n+1 got v=%b want v=0", rotValid);
      end
      @(negedge clk);
      total++;
      if (rotValid !== 1'b1 || rotCh !== 2'd0 || rotReal !== 18'h10000 || rotImag !== 18'h0) begin
         bad++;
         $display("FAIL latency_n+2 got v=%b ch=%0d re=%h im=%h want v=1 ch=0 re=10000 im=0",
                  rotValid, rotCh, rotReal, rotImag);
      end
      @(negedge clk);
      total++;
      if (rotValid !== 1'b0) begin
         bad++;
         $display("FAIL strobe_width got v=%b want v=0", rotValid);
      end
      @(posedge clk);
      #1;
      q.delete();
   endtask

   task automatic test_converge();
      out_t        o;
      bit          ok;
      logic [17:0] prev;
      logic [17:0] exp_ch [3];
      leakShift = 4'd3;
      for (int i = 0; i < 96; i++) drive(2'd1, 10'h100, 10'h000);
      settle();
      total++;
      if (q.size() != 96) begin
         bad++;
         $display("FAIL converge_count got %0d want 96", q.size());
      end
      prev = 18'h0;
      for (int i = 0; i < 96; i++) begin
         take(o, ok);
         total++;
         if (!ok || o.ch !== 2'd1 || o.re < prev || o.im !== 18'h0) begin
            bad++;
            $display("FAIL converge[%0d] got ch=%0d re=%h im=%h prev=%h want ch=1 re>=prev im=0",
                     i, o.ch, o.re, o.im, prev);
         end
         if (i == 0) begin
            total++;
            if (o.re !== 18'h02000) begin
               bad++;
               $display("FAIL converge_first got re=%h want 02000", o.re);
            end
         end
         if (i == 1) begin
            total++;
            if (o.re !== 18'h03C00) begin
               bad++;
               $display("FAIL converge_second got re=%h want 03c00", o.re);
            end
         end
         if (i == 95) begin
            total++;
            if (o.re < 18'h0FFFF || o.re > 18'h10001) begin
               bad++;
               $display("FAIL converge_final got re=%h want 0ffff..10001", o.re);
            end
         end
         prev = o.re;
      end
      // Frozen samples expose stored state without disturbing it.
      freeze = 1'b1;
      drive(2'd0, 10'h155, 10'h0AA);
      drive(2'd2, 10'h155, 10'h0AA);
      drive(2'd3, 10'h155, 10'h0AA);
      settle();
      freeze = 1'b0;
      exp_ch = '{18'h10000, 18'h00000, 18'h00000};
      for (int i = 0; i < 3; i++) begin
         take(o, ok);
         total++;
         if (!ok || o.re !== exp_ch[i] || o.im !== 18'h0) begin
            bad++;
            $display("FAIL other_ch[%0d] got ch=%0d re=%h im=%h want re=%h im=0", i, o.ch, o.re, o.im, exp_ch[i]);
         end
      end
   endtask

   task automatic test_neg_sat();
      out_t o;
      bit   ok;
      leakShift = 4'd0;
      drive(2'd3, 10'h000, 10'h200);
      settle();
      take(o, ok);
      total++;
      if (!ok || o.ch !== 2'd3 || o.re !== 18'h0 || o.im !== 18'h1FFFF) begin
         bad++;
         $display("FAIL neg_sat got ch=%0d re=%h im=%h want ch=3 re=0 im=1ffff", o.ch, o.re, o.im);
      end
      total++;
      if (satFlag !== 1'b0) begin
         bad++;
         $display("FAIL neg_sat_flag got %b want 0", satFlag);
      end
   endtask

   task automatic test_back_to_back();
      out_t        o;
      bit          ok;
      logic [17:0] exp_re [3];
      exp_re = '{18'h08000, 18'h0C000, 18'h0E000};
      leakShift = 4'd1;
      for (int i = 0; i < 3; i++) drive(2'd2, 10'h100, 10'h000);
      settle();
      for (int i = 0; i < 3; i++) begin
         take(o, ok);
         total++;
         if (!ok || o.ch !== 2'd2 || o.re !== exp_re[i] || o.im !== 18'h0) begin
            bad++;
            $display("FAIL b2b[%0d] got ch=%0d re=%h im=%h want ch=2 re=%h im=0", i, o.ch, o.re, o.im, exp_re[i]);
         end
      end
   endtask

   task automatic test_enable();
      out_t o;
      bit   ok;
      enableLoop = 1'b0;
      leakShift  = 4'd0;
      drive(2'd0, 10'h080, 10'h040);
      drive(2'd0, 10'h0C0, 10'h040);
      settle();
      for (int i = 0; i < 2; i++) begin
         take(o, ok);
         total++;
         if (!ok || o.re !== 18'h04000 || o.im !== 18'h0) begin
            bad++;
            $display("FAIL disabled[%0d] got re=%h im=%h want re=04000 im=0", i, o.re, o.im);
         end
      end
      enableLoop = 1'b1;
      leakShift  = 4'd1;
      drive(2'd0, 10'h100, 10'h000);
      settle();
      take(o, ok);
      total++;
      if (!ok || o.ch !== 2'd0 || o.re !== 18'h0E000 || o.im !== 18'h3E000) begin
         bad++;
         $display("FAIL reenable got ch=%0d re=%h im=%h want ch=0 re=0e000 im=3e000", o.ch, o.re, o.im);
      end
   endtask

   task automatic test_freeze_clear();
      out_t        o;
      bit          ok;
      logic [17:0] exp_re [4];
      freeze    = 1'b1;
      leakShift = 4'd2;
      for (int i = 0; i < 5; i++) drive(2'd2, 10'h100, 10'h100);
      settle();
      freeze = 1'b0;
      for (int i = 0; i < 5; i++) begin
         take(o, ok);
         total++;
         if (!ok || o.ch !== 2'd2 || o.re !== 18'h0E000 || o.im !== 18'h0) begin
            bad++;
            $display("FAIL frozen[%0d] got ch=%0d re=%h im=%h want ch=2 re=0e000 im=0", i, o.ch, o.re, o.im);
         end
      end
      // Clear lands while sample A is in stage 2 and sample B is reading ch2.
      drive(2'd2, 10'h100, 10'h000);
      clearValid = 1'b1;
      clearCh    = 2'd2;
      drive(2'd2, 10'h100, 10'h000);
      clearValid = 1'b0;
      // Sample D collides with a clear that has no stage-1 follower.
      drive(2'd2, 10'h100, 10'h000);
      clearValid = 1'b1;
      @(posedge clk);
      #1;
      clearValid = 1'b0;
      settle();
      freeze = 1'b1;
      drive(2'd2, 10'h100, 10'h000);
      settle();
      freeze = 1'b0;
      exp_re = '{18'h0E800, 18'h04000, 18'h07000, 18'h00000};
      for (int i = 0; i < 4; i++) begin
         take(o, ok);
         total++;
         if (!ok || o.ch !== 2'd2 || o.re !== exp_re[i] || o.im !== 18'h0) begin
            bad++;
            $display("FAIL clear[%0d] got ch=%0d re=%h im=%h want ch=2 re=%h im=0", i, o.ch, o.re, o.im, exp_re[i]);
         end
      end
   endtask

   task automatic test_midflight_reset();
      out_t o;
      bit   ok;
      q.delete();
      drive(2'd1, 10'h100, 10'h100);
      reset = 1'b1;
      #1;
      total++;
      if (rotValid !== 1'b0 || rotReal !== 18'h04000 || rotImag !== 18'h0) begin
         bad++;
         $display("FAIL async_reset got v=%b re=%h im=%h want v=0 re=04000 im=0", rotValid, rotReal, rotImag);
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      settle();
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL dropped_inflight got outputs=%0d want 0", q.size());
      end
      freeze    = 1'b1;
      leakShift = 4'd0;
      drive(2'd0, 10'h100, 10'h000);
      settle();
      freeze = 1'b0;
      take(o, ok);
      total++;
      if (!ok || o.re !== 18'h0 || o.im !== 18'h0 || satFlag !== 1'b0) begin
         bad++;
         $display("FAIL acc_after_reset got re=%h im=%h sat=%b want re=0 im=0 sat=0", o.re, o.im, satFlag);
      end
   endtask

   initial begin
      clk        = 1'b0;
      reset      = 1'b1;
      errValid   = 1'b0;
      errCh      = 2'd0;
      errReal    = '0;
      errImag    = '0;
      leakShift  = 4'd0;
      enableLoop = 1'b1;
      freeze     = 1'b0;
      clearValid = 1'b0;
      clearCh    = 2'd0;
      test_reset();
      test_latency_k0();
      test_converge();
      test_neg_sat();
      test_back_to_back();
      test_enable();
      test_freeze_clear();
      test_midflight_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
